// File: rtl/color_board_writer_pkg.sv
// Shared constants and types for the colour-attribute writer: the VRAM window,
// the register addresses, the reset colour and the fill FSM states.
package color_board_writer_pkg;

  localparam logic [15:0] VRAM_BASE   = 16'h0100;
  localparam int unsigned CELLS       = 768;
  localparam logic [15:0] VRAM_LAST   = VRAM_BASE + 16'(CELLS - 1);
  localparam logic [9:0]  CNT_LAST    = 10'(CELLS - 1);
  localparam logic [15:0] COLOR_REG   = 16'hEE40;
  localparam logic [15:0] FILL_REG    = 16'hEE41;
  localparam logic [7:0]  RESET_LATCH = 8'h07;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic logic in_vram(input logic [15:0] addr);
    return (addr >= VRAM_BASE) && (addr <= VRAM_LAST);
  endfunction

endpackage

// File: rtl/color_board_writer.sv
// Mirrors CPU text-VRAM writes into the colour RAM using the colour latch, and
// runs a fill engine that paints every cell with one attribute.
module color_board_writer
  import color_board_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        color_board,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic [7:0]  color_latch,
  output logic [7:0]  charcolor,
  output logic [9:0]  color_ram_addr,
  output logic        color_ram_wr,
  output logic        busy
);

  logic       w_mirror;
  logic       w_color_wr;
  logic       w_fill_wr;
  logic [9:0] w_index;

  state_t     r_state;
  logic [9:0] r_cnt;
  logic [7:0] r_fill_byte;
  logic [7:0] r_latch;
  logic [7:0] r_charcolor;
  logic [9:0] r_addr;
  logic       r_wr;
  logic       r_busy;

  assign w_mirror   = cpu_we && color_board && in_vram(cpu_addr);
  assign w_color_wr = cpu_we && color_board && (cpu_addr == COLOR_REG);
  assign w_fill_wr  = cpu_we && color_board && (cpu_addr == FILL_REG);
  // Inside the window the offset fits in 10 bits, so only the low bits matter.
  assign w_index    = cpu_addr[9:0] - VRAM_BASE[9:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_fill_byte <= '0;
      r_latch     <= RESET_LATCH;
      r_charcolor <= '0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_busy      <= 1'b0;
    end else if (!color_board) begin
      r_state <= IDLE;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      // CPU mirror writes win the RAM port; the fill simply holds its index.
      if (w_mirror) begin
        r_wr        <= 1'b1;
        r_addr      <= w_index;
        r_charcolor <= r_latch;
      end else if (r_state == FILL) begin
        r_wr        <= 1'b1;
        r_addr      <= r_cnt;
        r_charcolor <= r_fill_byte;
        if (r_cnt == CNT_LAST) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 10'd1;
        end
      end

      if (w_color_wr) begin
        r_latch <= cpu_dout;
      end

      // A new fill request restarts from cell 0 regardless of progress.
      if (w_fill_wr) begin
        r_fill_byte <= cpu_dout;
        r_cnt       <= '0;
        r_state     <= FILL;
        r_busy      <= 1'b1;
      end
    end
  end

  assign color_latch    = r_latch;
  assign charcolor      = r_charcolor;
  assign color_ram_addr = r_addr;
  assign color_ram_wr   = r_wr;
  assign busy           = r_busy;

endmodule

// File: tb/tb_color_board_writer.sv
// Directed bench for color_board_writer: mirror writes, latch, fill, stall,
// restart, reset abort and colour-board disable.
module tb_color_board_writer;

  logic        clk;
  logic        reset_n;
  logic        color_board;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic [7:0]  color_latch;
  logic [7:0]  charcolor;
  logic [9:0]  color_ram_addr;
  logic        color_ram_wr;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [9:0] log_addr[$];
  logic [7:0] log_data[$];
  int         busy_cnt;

  color_board_writer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .color_board    (color_board),
    .cpu_addr       (cpu_addr),
    .cpu_dout       (cpu_dout),
    .cpu_we         (cpu_we),
    .color_latch    (color_latch),
    .charcolor      (charcolor),
    .color_ram_addr (color_ram_addr),
    .color_ram_wr   (color_ram_wr),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (color_ram_wr === 1'b1) begin
      log_addr.push_back(color_ram_addr);
      log_data.push_back(charcolor);
    end
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    busy_cnt = 0;
  endtask

  // Called at a negedge; the write is sampled at the following posedge and the
  // task returns at the negedge after it, where the result is already visible.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_dout = d;
    cpu_we   = 1'b1;
    @(negedge clk);
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout busy=%b after %0d cycles, required 0", name, busy, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; color_board = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_dout = '0;
    #12;
    checks++;
    if ({color_latch, charcolor, color_ram_addr, color_ram_wr, busy} !== {8'h07, 8'h00, 10'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset latch=%h char=%h addr=%0d wr=%b busy=%b, required 07 00 0 0 0",
               color_latch, charcolor, color_ram_addr, color_ram_wr, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mirror();
    cpu_write(16'h0100, 8'h41);
    checks++;
    if ({color_ram_wr, color_ram_addr, charcolor} !== {1'b1, 10'd0, 8'h07}) begin
      failures++;
      $display("FAIL mirror_first wr=%b addr=%0d char=%h, required 1 0 07", color_ram_wr, color_ram_addr, charcolor);
    end
    @(negedge clk);
    checks++;
    if (color_ram_wr !== 1'b0) begin
      failures++;
      $display("FAIL mirror_one_pulse wr=%b, required 0", color_ram_wr);
    end
  endtask

  task automatic test_color_reg();
    cpu_write(16'hEE40, 8'h52);
    checks++;
    if (color_latch !== 8'h52 || color_ram_wr !== 1'b0) begin
      failures++;
      $display("FAIL color_reg latch=%h wr=%b, required 52 0", color_latch, color_ram_wr);
    end
    cpu_write(16'h03FF, 8'h99);
    checks++;
    if ({color_ram_wr, color_ram_addr, charcolor} !== {1'b1, 10'd767, 8'h52}) begin
      failures++;
      $display("FAIL mirror_last wr=%b addr=%0d char=%h, required 1 767 52", color_ram_wr, color_ram_addr, charcolor);
    end
    cpu_write(16'h0400, 8'h99);
    checks++;
    if (color_ram_wr !== 1'b0) begin
      failures++;
      $display("FAIL above_window wr=%b, required 0", color_ram_wr);
    end
    cpu_write(16'h00FF, 8'h99);
    checks++;
    if (color_ram_wr !== 1'b0) begin
      failures++;
      $display("FAIL below_window wr=%b, required 0", color_ram_wr);
    end
  endtask

  task automatic test_fill();
    int bad;
    clear_log();
    cpu_write(16'hEE41, 8'h70);
    checks++;
    if (busy !== 1'b1 || color_ram_wr !== 1'b0) begin
      failures++;
      $display("FAIL fill_start busy=%b wr=%b, required 1 0", busy, color_ram_wr);
    end
    wait_idle("fill", 2000);
    checks++;
    if (log_addr.size() != 768 || busy_cnt != 768) begin
      failures++;
      $display("FAIL fill_count pulses=%0d busy_cycles=%0d, required 768 768", log_addr.size(), busy_cnt);
    end
    bad = -1;
    foreach (log_addr[i]) if (bad < 0 && (log_addr[i] !== 10'(i) || log_data[i] !== 8'h70)) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL fill_seq at %0d addr=%0d data=%h, required %0d 70", bad, log_addr[bad], log_data[bad], bad);
    end
  endtask

  task automatic test_fill_interleave();
    int bad;
    int k;
    clear_log();
    cpu_write(16'hEE41, 8'h70);
    repeat (10) @(negedge clk);
    cpu_addr = 16'h0200; cpu_dout = 8'hAA; cpu_we = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = '0;
    wait_idle("interleave", 2000);
    checks++;
    if (log_addr.size() != 770 || busy_cnt != 770) begin
      failures++;
      $display("FAIL interleave_count pulses=%0d busy_cycles=%0d, required 770 770", log_addr.size(), busy_cnt);
    end
    checks++;
    if (log_addr.size() < 12 ||
        {log_addr[10], log_data[10], log_addr[11], log_data[11]} !== {10'd256, 8'h52, 10'd256, 8'h52}) begin
      failures++;
      $display("FAIL interleave_mirror pulses 10/11 not addr 256 data 52 (size=%0d)", log_addr.size());
    end
    bad = -1; k = 0;
    foreach (log_addr[i]) begin
      if (i == 10 || i == 11) continue;
      if (bad < 0 && (log_addr[i] !== 10'(k) || log_data[i] !== 8'h70)) bad = i;
      k++;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL interleave_seq at pulse %0d addr=%0d data=%h, required fill order data 70", bad, log_addr[bad], log_data[bad]);
    end
  endtask

  task automatic test_restart_abort();
    clear_log();
    cpu_write(16'hEE41, 8'h11);
    repeat (300) @(negedge clk);
    cpu_write(16'hEE41, 8'h22);
    repeat (3) @(negedge clk);
    checks++;
    if (log_addr.size() < 303 ||
        {log_addr[300], log_data[300], log_addr[301], log_data[301], log_addr[302], log_data[302]}
        !== {10'd300, 8'h11, 10'd0, 8'h22, 10'd1, 8'h22}) begin
      failures++;
      $display("FAIL restart sequence around index 300 wrong (size=%0d)", log_addr.size());
    end
    repeat (50) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (color_ram_wr !== 1'b0 || busy !== 1'b0 || color_latch !== 8'h07) begin
      failures++;
      $display("FAIL reset_abort wr=%b busy=%b latch=%h, required 0 0 07", color_ram_wr, busy, color_latch);
    end
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    repeat (20) @(negedge clk);
    checks++;
    if (log_addr.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_reset pulses=%0d busy=%b, required 0 0", log_addr.size(), busy);
    end
  endtask

  task automatic test_board_off();
    int n;
    clear_log();
    color_board = 1'b0;
    cpu_write(16'h0150, 8'h01);
    cpu_write(16'hEE40, 8'h33);
    cpu_write(16'hEE41, 8'h44);
    repeat (5) @(negedge clk);
    checks++;
    if (log_addr.size() != 0 || busy !== 1'b0 || color_latch !== 8'h07) begin
      failures++;
      $display("FAIL board_off pulses=%0d busy=%b latch=%h, required 0 0 07", log_addr.size(), busy, color_latch);
    end
    color_board = 1'b1;
    cpu_write(16'hEE41, 8'h5A);
    repeat (20) @(negedge clk);
    color_board = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || color_ram_wr !== 1'b0) begin
      failures++;
      $display("FAIL board_drop busy=%b wr=%b, required 0 0", busy, color_ram_wr);
    end
    n = log_addr.size();
    repeat (5) @(negedge clk);
    color_board = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (log_addr.size() != n || busy !== 1'b0) begin
      failures++;
      $display("FAIL board_no_resume pulses=%0d busy=%b, required %0d 0", log_addr.size(), busy, n);
    end
  endtask

  initial begin
    test_reset();
    test_mirror();
    test_color_reg();
    test_fill();
    test_fill_interleave();
    test_restart_abort();
    test_board_off();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
